// File: rtl/vx_tcu_drl_kloop_ctrl.sv
// K-loop sequencer for the TCU DRL FEDP datapath: issues one step per cycle,
// merges per-step exception returns into one sticky job result.

package vx_tcu_drl_kloop_pkg;
  localparam logic [2:0] TCU_FP32_ID = 3'd0;
  localparam logic [2:0] TCU_FP16_ID = 3'd1;
  localparam logic [2:0] TCU_BF16_ID = 3'd2;

  typedef struct packed {
    logic sign;
    logic is_nan;
    logic is_inf;
  } fedp_excep_t;
endpackage

// state | meaning
// IDLE  | waiting for a job, req_ready=1
// ISSUE | presenting step_cnt to the datapath
// DRAIN | all steps issued, collecting outstanding returns
// RESP  | merged result held on rsp_* until rsp_ready
module vx_tcu_drl_kloop_ctrl
  import vx_tcu_drl_kloop_pkg::*;
#(
  parameter int N     = 2,
  parameter int TCK   = 2 * N,
  parameter int STEPW = 4,
  parameter int TAGW  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_fmtf,
  input  logic [STEPW-1:0] req_steps,
  input  logic [TAGW-1:0]  req_tag,
  output logic             dp_issue_valid,
  input  logic             dp_stall,
  output logic [2:0]       dp_fmtf,
  output logic [STEPW-1:0] dp_step,
  output logic             dp_first,
  output logic             dp_last,
  input  logic             dp_excep_valid,
  input  fedp_excep_t      dp_excep,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output fedp_excep_t      rsp_excep,
  output logic [TAGW-1:0]  rsp_tag
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
  localparam logic [STEPW-1:0] ONE = STEPW'(1);

  // Lane counts only size the downstream datapath; no logic here depends on them.
  if (N < 1 || TCK < 1) begin : g_lane_cfg_unused
  end

  state_t           state_q, state_d;
  logic [2:0]       fmtf_q;
  logic [STEPW-1:0] steps_q, steps_eff;
  logic [STEPW-1:0] step_cnt, ret_cnt, ret_cnt_d;
  logic             nan_q, pos_q, neg_q;
  logic             nan_d, pos_d, neg_d, m_nan;
  logic             fmt_ok, last_step, issue_fire, ret_take, drain_done;
  fedp_excep_t      merged;

  assign fmt_ok     = (req_fmtf == TCU_FP32_ID) || (req_fmtf == TCU_FP16_ID) ||
                      (req_fmtf == TCU_BF16_ID);
  assign steps_eff  = (req_steps == '0) ? ONE : req_steps;
  assign last_step  = (step_cnt == steps_q - ONE);
  assign issue_fire = (state_q == ISSUE) && !dp_stall;

  // Returns beyond the job length, or outside ISSUE/DRAIN, are dropped.
  assign ret_take   = dp_excep_valid && ((state_q == ISSUE) || (state_q == DRAIN)) &&
                      (ret_cnt != steps_q);
  assign ret_cnt_d  = ret_take ? ret_cnt + ONE : ret_cnt;
  assign nan_d      = nan_q | (ret_take & dp_excep.is_nan);
  assign pos_d      = pos_q | (ret_take & dp_excep.is_inf & ~dp_excep.sign);
  assign neg_d      = neg_q | (ret_take & dp_excep.is_inf & dp_excep.sign);
  assign drain_done = (state_q == DRAIN) && (ret_cnt_d == steps_q);

  // Opposite-sign infinities across steps collapse into NaN.
  assign m_nan  = nan_d | (pos_d & neg_d);
  assign merged = '{sign: neg_d & ~pos_d, is_nan: m_nan, is_inf: (pos_d | neg_d) & ~m_nan};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = fmt_ok ? ISSUE : RESP;
      ISSUE:   if (issue_fire && last_step) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == IDLE);
    dp_issue_valid = (state_q == ISSUE);
    dp_first       = (state_q == ISSUE) && (step_cnt == '0);
    dp_last        = (state_q == ISSUE) && last_step;
    rsp_valid      = (state_q == RESP);
  end

  assign dp_step = step_cnt;
  assign dp_fmtf = fmtf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fmtf_q    <= '0;
      steps_q   <= '0;
      step_cnt  <= '0;
      ret_cnt   <= '0;
      nan_q     <= 1'b0;
      pos_q     <= 1'b0;
      neg_q     <= 1'b0;
      rsp_excep <= '0;
      rsp_tag   <= '0;
    end else if (state_q == IDLE) begin
      if (req_valid) begin
        fmtf_q    <= req_fmtf;
        steps_q   <= steps_eff;
        rsp_tag   <= req_tag;
        step_cnt  <= '0;
        ret_cnt   <= '0;
        nan_q     <= 1'b0;
        pos_q     <= 1'b0;
        neg_q     <= 1'b0;
        rsp_excep <= '0;
      end
    end else begin
      if (issue_fire) step_cnt <= step_cnt + ONE;
      ret_cnt <= ret_cnt_d;
      nan_q   <= nan_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      if (drain_done) rsp_excep <= merged;
    end
  end

endmodule

// File: tb/tb_vx_tcu_drl_kloop_ctrl.sv
// Self-checking bench for vx_tcu_drl_kloop_ctrl with a fixed-latency datapath
// emulator and a behavioural model of the merged job exception.

module tb_vx_tcu_drl_kloop_ctrl;
  import vx_tcu_drl_kloop_pkg::*;

  localparam int STEPW = 4;
  localparam int TAGW  = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid, req_ready;
  logic [2:0]       req_fmtf;
  logic [STEPW-1:0] req_steps;
  logic [TAGW-1:0]  req_tag;
  logic             dp_issue_valid, dp_stall;
  logic [2:0]       dp_fmtf;
  logic [STEPW-1:0] dp_step;
  logic             dp_first, dp_last;
  logic             dp_excep_valid;
  fedp_excep_t      dp_excep;
  logic             rsp_valid, rsp_ready;
  fedp_excep_t      rsp_excep;
  logic [TAGW-1:0]  rsp_tag;

  vx_tcu_drl_kloop_ctrl #(.N(2), .TCK(4), .STEPW(STEPW), .TAGW(TAGW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmtf(req_fmtf),
    .req_steps(req_steps), .req_tag(req_tag),
    .dp_issue_valid(dp_issue_valid), .dp_stall(dp_stall), .dp_fmtf(dp_fmtf),
    .dp_step(dp_step), .dp_first(dp_first), .dp_last(dp_last),
    .dp_excep_valid(dp_excep_valid), .dp_excep(dp_excep),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_excep(rsp_excep), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  typedef struct { int due; fedp_excep_t ex; } ret_t;
  typedef struct { int step; bit is_first; bit is_last; logic [2:0] fmt; } iss_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 2;
  int          stall_pct = 0;
  bit          stall_force = 1'b0;
  bit          extra_ret = 1'b0;
  fedp_excep_t ret_tab [16];
  ret_t        rq [$];
  iss_t        ilog [$];

  // Datapath emulator: logs completed issues, returns ret_tab[step] lat cycles later.
  always @(posedge clk) begin
    if (reset_n && dp_issue_valid && !dp_stall) begin
      ilog.push_back('{step: int'(dp_step), is_first: dp_first, is_last: dp_last, fmt: dp_fmtf});
      rq.push_back('{due: cyc + lat, ex: ret_tab[dp_step]});
      if (extra_ret && dp_last)
        rq.push_back('{due: cyc + lat + 1, ex: '{sign: 1'b0, is_nan: 1'b1, is_inf: 1'b0}});
    end
    cyc = cyc + 1;
    #1;
    dp_stall       = stall_force || ($urandom_range(0, 99) < stall_pct);
    dp_excep_valid = 1'b0;
    dp_excep       = '0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      dp_excep_valid = 1'b1;
      dp_excep       = rq[0].ex;
      void'(rq.pop_front());
    end
  end

  function automatic bit fmt_supported(logic [2:0] f);
    return (f == TCU_FP32_ID) || (f == TCU_FP16_ID) || (f == TCU_BF16_ID);
  endfunction

  function automatic int eff_steps(logic [2:0] f, int s);
    if (!fmt_supported(f)) return 0;
    return (s == 0) ? 1 : s;
  endfunction

  // A job's exception from the set of per-step returns it consumed.
  function automatic fedp_excep_t model_excep(logic [2:0] f, int s);
    bit any_nan = 0, any_pinf = 0, any_ninf = 0;
    fedp_excep_t r = '0;
    for (int k = 0; k < eff_steps(f, s); k++) begin
      any_nan |= ret_tab[k].is_nan;
      if (ret_tab[k].is_inf) begin
        if (ret_tab[k].sign) any_ninf = 1;
        else                 any_pinf = 1;
      end
    end
    r.is_nan = any_nan || (any_pinf && any_ninf);
    r.is_inf = (any_pinf || any_ninf) && !r.is_nan;
    r.sign   = any_ninf && !any_pinf;
    return r;
  endfunction

  // Stimulus driver only: runs one job through request and response handshakes.
  task automatic run_job(input logic [2:0] fmt, input logic [STEPW-1:0] steps,
                         input logic [TAGW-1:0] tag, input int rdy_delay,
                         output int latency, output fedp_excep_t ex,
                         output logic [TAGW-1:0] tag_o, output bit timeout, output bit held);
    int acc;
    int n;
    timeout = 0; held = 1; latency = -1; ex = '0; tag_o = '0;
    ilog.delete();
    req_fmtf = fmt; req_steps = steps; req_tag = tag; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin timeout = 1; req_valid = 1'b0; return; end
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 300) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) begin timeout = 1; return; end
    latency = cyc - acc;
    ex = rsp_excep;
    tag_o = rsp_tag;
    for (int i = 0; i < rdy_delay; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_excep !== ex || rsp_tag !== tag_o) held = 0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic clear_tab();
    for (int k = 0; k < 16; k++) ret_tab[k] = '0;
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_fmtf = TCU_FP16_ID; req_steps = 4'd3; req_tag = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (dp_issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0", dp_issue_valid); end
    checks++; if (rsp_tag !== 8'h00) begin errors++; $display("FAIL reset_rsp_tag: got %h expected 00", rsp_tag); end
    checks++; if (rsp_excep !== 3'b000) begin errors++; $display("FAIL reset_rsp_excep: got %b expected 000", rsp_excep); end
    req_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || dp_issue_valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_accept: got ready=%b issue=%b expected ready=1 issue=0", req_ready, dp_issue_valid);
    end
  endtask

  task automatic test_basic_fp16();
    int latency; fedp_excep_t ex; logic [TAGW-1:0] t; bit to, held;
    clear_tab(); lat = 2;
    run_job(TCU_FP16_ID, 4'd4, 8'hA5, 0, latency, ex, t, to, held);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got timeout expected response"); end
    checks++; if (latency !== 7) begin errors++; $display("FAIL basic_latency: got %0d expected 7", latency); end
    checks++; if (ex !== model_excep(TCU_FP16_ID, 4)) begin errors++; $display("FAIL basic_excep: got %b expected %b", ex, model_excep(TCU_FP16_ID, 4)); end
    checks++; if (t !== 8'hA5) begin errors++; $display("FAIL basic_tag: got %h expected a5", t); end
    checks++; if (ilog.size() != 4) begin errors++; $display("FAIL basic_issue_count: got %0d expected 4", ilog.size()); end
    for (int k = 0; k < ilog.size(); k++) begin
      checks++;
      if (ilog[k].step != k || ilog[k].is_first != (k == 0) || ilog[k].is_last != (k == 3) || ilog[k].fmt !== TCU_FP16_ID) begin
        errors++;
        $display("FAIL basic_issue%0d: got step=%0d first=%b last=%b fmt=%0d expected step=%0d first=%b last=%b fmt=1",
                 k, ilog[k].step, ilog[k].is_first, ilog[k].is_last, ilog[k].fmt, k, k == 0, k == 3);
      end
    end
  endtask

  task automatic test_bf16_opposite_inf();
    int latency; fedp_excep_t ex; logic [TAGW-1:0] t; bit to, held;
    clear_tab(); lat = 2;
    ret_tab[1] = '{sign: 1'b0, is_nan: 1'b0, is_inf: 1'b1};
    ret_tab[2] = '{sign: 1'b1, is_nan: 1'b0, is_inf: 1'b1};
    run_job(TCU_BF16_ID, 4'd3, 8'h3C, 1, latency, ex, t, to, held);
    checks++; if (to || latency !== 6) begin errors++; $display("FAIL bf16_latency: got %0d (timeout=%b) expected 6", latency, to); end
    checks++; if (ex !== model_excep(TCU_BF16_ID, 3)) begin errors++; $display("FAIL bf16_excep: got %b expected %b", ex, model_excep(TCU_BF16_ID, 3)); end
    checks++; if (t !== 8'h3C) begin errors++; $display("FAIL bf16_tag: got %h expected 3c", t); end
  endtask

  task automatic test_fp32_neg_inf();
    int latency; fedp_excep_t ex; logic [TAGW-1:0] t; bit to, held;
    clear_tab(); lat = 1;
    ret_tab[1] = '{sign: 1'b1, is_nan: 1'b0, is_inf: 1'b1};
    run_job(TCU_FP32_ID, 4'd2, 8'hF0, 0, latency, ex, t, to, held);
    checks++; if (to || latency !== 4) begin errors++; $display("FAIL fp32_latency: got %0d (timeout=%b) expected 4", latency, to); end
    checks++; if (ex !== model_excep(TCU_FP32_ID, 2)) begin errors++; $display("FAIL fp32_excep: got %b expected %b", ex, model_excep(TCU_FP32_ID, 2)); end
  endtask

  task automatic test_zero_steps_and_bad_fmt();
    int latency; fedp_excep_t ex; logic [TAGW-1:0] t; bit to, held;
    for (int k = 0; k < 16; k++) ret_tab[k] = '{sign: 1'b1, is_nan: 1'b0, is_inf: 1'b1};
    lat = 2;
    run_job(3'b111, 4'd5, 8'h77, 0, latency, ex, t, to, held);
    checks++; if (to || latency !== 1) begin errors++; $display("FAIL badfmt_latency: got %0d (timeout=%b) expected 1", latency, to); end
    checks++; if (ex !== 3'b000) begin errors++; $display("FAIL badfmt_excep: got %b expected 000", ex); end
    checks++; if (ilog.size() != 0) begin errors++; $display("FAIL badfmt_issue_count: got %0d expected 0", ilog.size()); end
    checks++; if (t !== 8'h77) begin errors++; $display("FAIL badfmt_tag: got %h expected 77", t); end
    clear_tab();
    run_job(TCU_FP16_ID, 4'd0, 8'h01, 0, latency, ex, t, to, held);
    checks++; if (to || latency !== 4) begin errors++; $display("FAIL zero_latency: got %0d (timeout=%b) expected 4", latency, to); end
    checks++; if (ilog.size() != 1) begin errors++; $display("FAIL zero_issue_count: got %0d expected 1", ilog.size()); end
    else begin
      checks++; if (ilog[0].step != 0 || !ilog[0].is_first || !ilog[0].is_last) begin
        errors++; $display("FAIL zero_first_last: got step=%0d first=%b last=%b expected 0 1 1", ilog[0].step, ilog[0].is_first, ilog[0].is_last);
      end
    end
  endtask

  task automatic test_stall_backpressure();
    int latency; fedp_excep_t ex; logic [TAGW-1:0] t; bit to, held;
    int n;
    clear_tab(); lat = 2;
    ret_tab[3] = '{sign: 1'b1, is_nan: 1'b0, is_inf: 1'b1};
    fork
      run_job(TCU_FP16_ID, 4'd4, 8'hC3, 2, latency, ex, t, to, held);
      begin
        n = 0;
        while (!(dp_issue_valid && dp_step == 4'd2) && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk);
        stall_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
          #2;
          checks++;
          if (dp_issue_valid !== 1'b1 || dp_step !== 4'd3 || dp_last !== 1'b1 || dp_first !== 1'b0 || dp_fmtf !== TCU_FP16_ID) begin
            errors++;
            $display("FAIL stall_hold%0d: got valid=%b step=%0d first=%b last=%b fmt=%0d expected 1 3 0 1 1",
                     i, dp_issue_valid, dp_step, dp_first, dp_last, dp_fmtf);
          end
          @(posedge clk);
        end
        stall_force = 1'b0;
      end
    join
    checks++; if (to || latency !== 10) begin errors++; $display("FAIL stall_latency: got %0d (timeout=%b) expected 10", latency, to); end
    checks++; if (!held) begin errors++; $display("FAIL stall_rsp_hold: got rsp fields changing expected stable"); end
    checks++; if (ex !== model_excep(TCU_FP16_ID, 4)) begin errors++; $display("FAIL stall_excep: got %b expected %b", ex, model_excep(TCU_FP16_ID, 4)); end
    checks++; if (ilog.size() != 4) begin errors++; $display("FAIL stall_issue_count: got %0d expected 4", ilog.size()); end
    else begin
      checks++; if (ilog[0].step != 0 || ilog[1].step != 1 || ilog[2].step != 2 || ilog[3].step != 3) begin
        errors++; $display("FAIL stall_issue_order: got %0d %0d %0d %0d expected 0 1 2 3", ilog[0].step, ilog[1].step, ilog[2].step, ilog[3].step);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int latency; fedp_excep_t ex; logic [TAGW-1:0] t; bit to, held;
    for (int k = 0; k < 16; k++) ret_tab[k] = '{sign: 1'b0, is_nan: 1'b1, is_inf: 1'b0};
    lat = 3;
    req_fmtf = TCU_FP32_ID; req_steps = 4'd4; req_tag = 8'h99; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (dp_issue_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL abort_in_drain: got issue=%b rsp=%b ready=%b expected 0 0 0", dp_issue_valid, rsp_valid, req_ready);
    end
    reset_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_tag !== 8'h00 || rsp_excep !== 3'b000) begin
      errors++; $display("FAIL abort_reset_state: got rsp=%b ready=%b tag=%h ex=%b expected 0 1 00 000", rsp_valid, req_ready, rsp_tag, rsp_excep);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || dp_issue_valid !== 1'b0) begin
      errors++; $display("FAIL abort_no_response: got rsp=%b ready=%b issue=%b expected 0 1 0", rsp_valid, req_ready, dp_issue_valid);
    end
    clear_tab();
    run_job(TCU_FP16_ID, 4'd2, 8'h42, 0, latency, ex, t, to, held);
    checks++; if (to || latency !== 6) begin errors++; $display("FAIL abort_next_latency: got %0d (timeout=%b) expected 6", latency, to); end
    checks++; if (ex !== 3'b000 || t !== 8'h42) begin errors++; $display("FAIL abort_next_result: got ex=%b tag=%h expected 000 42", ex, t); end
  endtask

  task automatic test_random_jobs();
    int latency; fedp_excep_t ex; logic [TAGW-1:0] t; bit to, held;
    logic [2:0] fmt; logic [STEPW-1:0] steps; logic [TAGW-1:0] tag;
    int r, rdy, n_exp, exp_lat;
    bit ok;
    for (int j = 0; j < 24; j++) begin
      r = $urandom_range(0, 9);
      fmt = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      steps = STEPW'($urandom_range(0, 15));
      tag = TAGW'($urandom);
      lat = $urandom_range(1, 3);
      stall_pct = ($urandom_range(0, 1) == 1) ? 30 : 0;
      extra_ret = ($urandom_range(0, 1) == 1);
      rdy = $urandom_range(0, 3);
      for (int k = 0; k < 16; k++)
        ret_tab[k] = ($urandom_range(0, 3) == 0) ? fedp_excep_t'(3'($urandom)) : '0;
      run_job(fmt, steps, tag, rdy, latency, ex, t, to, held);
      n_exp = eff_steps(fmt, int'(steps));
      exp_lat = fmt_supported(fmt) ? n_exp + lat + 1 : 1;
      checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: got timeout expected response", j); end
      checks++; if (ex !== model_excep(fmt, int'(steps))) begin
        errors++; $display("FAIL rand%0d_excep: got %b expected %b (fmt=%0d steps=%0d)", j, ex, model_excep(fmt, int'(steps)), fmt, steps);
      end
      checks++; if (t !== tag) begin errors++; $display("FAIL rand%0d_tag: got %h expected %h", j, t, tag); end
      checks++; if (!held) begin errors++; $display("FAIL rand%0d_rsp_hold: got rsp fields changing expected stable", j); end
      if (stall_pct == 0) begin
        checks++; if (latency !== exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", j, latency, exp_lat); end
      end
      ok = (ilog.size() == n_exp);
      for (int k = 0; k < ilog.size() && ok; k++)
        if (ilog[k].step != k || ilog[k].is_first != (k == 0) || ilog[k].is_last != (k == n_exp - 1) || ilog[k].fmt !== fmt) ok = 0;
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_issue_log: got %0d issues expected %0d in order 0..%0d", j, ilog.size(), n_exp, n_exp - 1); end
    end
    stall_pct = 0;
    extra_ret = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    req_valid = 1'b0; req_fmtf = '0; req_steps = '0; req_tag = '0;
    rsp_ready = 1'b0; dp_stall = 1'b0; dp_excep_valid = 1'b0; dp_excep = '0;
    clear_tab();
    #1 reset_n = 1'b0;
    test_reset();
    test_basic_fp16();
    test_bf16_opposite_inf();
    test_fp32_neg_inf();
    test_zero_steps_and_bad_fmt();
    test_stall_backpressure();
    test_reset_mid_job();
    test_random_jobs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
